// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the 32-bit AND/OR/adder ALU: runs single-cycle ops, derives SUB/SLT
// from the adder, and iterates the adder over 32 cycles for a low-word multiply.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_binvert,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err
);

  localparam logic [2:0] OpAnd = 3'd0;
  localparam logic [2:0] OpOr  = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpSub = 3'd3;
  localparam logic [2:0] OpSlt = 3'd4;
  localparam logic [2:0] OpMul = 3'd5;

  typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;  // operands; reused as multiplicand / multiplier during MUL
  logic [31:0] acc_q, acc_d;
  logic [4:0]  count_q;
  logic [31:0] rsp_data_q;
  logic        rsp_carry_q, rsp_err_q;
  logic        cmd_illegal, slt_ovf, slt_bit;

  assign cmd_illegal = (cmd_op[2:1] == 2'b11);
  assign cmd_ready   = (state_q == StIdle) && rst_n;
  assign rsp_valid   = (state_q == StResp);
  assign rsp_data    = rsp_data_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_err     = rsp_err_q;

  // Signed less-than: sign of A-B corrected for two's-complement overflow.
  assign slt_ovf = (a_q[31] != b_q[31]) && (alu_result[31] != a_q[31]);
  assign slt_bit = alu_result[31] ^ slt_ovf;
  assign acc_d   = b_q[0] ? alu_result : acc_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_illegal)          state_d = StResp;
          else if (cmd_op == OpMul) state_d = StMul;
          else                      state_d = StExec;
        end
      end
      StExec:  state_d = StResp;
      StMul:   if (count_q == 5'd31) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    alu_op      = 2'b00;
    alu_binvert = 1'b0;
    alu_cin     = 1'b0;
    unique case (state_q)
      StExec: begin
        alu_a = a_q;
        alu_b = b_q;
        unique case (op_q)
          OpOr:         alu_op = 2'b01;
          OpAdd:        alu_op = 2'b10;
          OpSub, OpSlt: begin
            alu_op      = 2'b10;
            alu_binvert = 1'b1;
            alu_cin     = 1'b1;
          end
          default:      alu_op = 2'b00;
        endcase
      end
      StMul: begin
        alu_a  = acc_q;
        alu_b  = a_q;
        alu_op = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= 3'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      acc_q       <= 32'd0;
      count_q     <= 5'd0;
      rsp_data_q  <= 32'd0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q        <= cmd_op;
            a_q         <= cmd_a;
            b_q         <= cmd_b;
            acc_q       <= 32'd0;
            count_q     <= 5'd0;
            rsp_data_q  <= 32'd0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= cmd_illegal;
          end
        end
        StExec: begin
          rsp_data_q  <= (op_q == OpSlt) ? {31'd0, slt_bit} : alu_result;
          rsp_carry_q <= ((op_q == OpAdd) || (op_q == OpSub)) && alu_cout;
        end
        StMul: begin
          acc_q   <= acc_d;
          a_q     <= a_q << 1;
          b_q     <= b_q >> 1;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) rsp_data_q <= acc_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU closing the loop.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        alu_binvert, alu_cin, alu_cout;
  logic        rsp_valid, rsp_ready, rsp_carry, rsp_err;
  logic [31:0] rsp_data;
  logic [32:0] sum;
  logic [31:0] bb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_binvert(alu_binvert), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  // Reference ALU: AND / OR / adder with b-invert and carry-in.
  always_comb begin
    bb  = alu_binvert ? ~alu_b : alu_b;
    sum = {1'b0, alu_a} + {1'b0, bb} + {32'd0, alu_cin};
    unique case (alu_op)
      2'b00:   alu_result = alu_a & bb;
      2'b01:   alu_result = alu_a | bb;
      2'b10:   alu_result = sum[31:0];
      default: alu_result = 32'd0;
    endcase
    alu_cout = sum[32];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int i;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    i = 0;
    while (!cmd_ready && i < 50) begin
      step();
      i++;
    end
    chk("issue_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Latency is the index of the edge at which rsp_valid is first sampled high.
  task automatic wait_rsp(input string tag, input int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
    end
    chk(tag, n + 1, lat);
  endtask

  task automatic finish_op(input string tag, input int lat, input logic [31:0] data,
                           input logic carry, input logic err);
    wait_rsp({tag, "_lat"}, lat);
    chk({tag, "_data"}, rsp_data, data);
    chk({tag, "_carry"}, {31'd0, rsp_carry}, {31'd0, carry});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, err});
    step();
    chk({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  logic seen;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    cmd_a     = 32'h1234_5678;
    cmd_b     = 32'h1;
    rsp_ready = 1'b1;
    step(); step(); step();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_ab", alu_a | alu_b, 32'd0);
    chk("rst_alu_ctl", {28'd0, alu_op, alu_binvert, alu_cin}, 32'd0);
    chk("rst_rsp", {rsp_data[29:0], rsp_carry, rsp_err}, 32'd0);
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    step();
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);

    issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0001);
    finish_op("add", 2, 32'h0, 1'b1, 1'b0);

    issue(3'd3, 32'd5, 32'd7);
    chk("sub_alu_ctl", {29'd0, alu_op, alu_binvert}, {29'd0, 2'b10, 1'b1});
    chk("sub_alu_cin", {31'd0, alu_cin}, 32'd1);
    chk("sub_alu_ab", alu_b, 32'd7);
    finish_op("sub", 2, 32'hFFFF_FFFE, 1'b0, 1'b0);

    issue(3'd4, 32'h8000_0000, 32'h0000_0001);
    finish_op("slt_neg_ovf", 2, 32'd1, 1'b0, 1'b0);
    issue(3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    finish_op("slt_pos_ovf", 2, 32'd0, 1'b0, 1'b0);
    issue(3'd4, 32'd3, 32'd3);
    finish_op("slt_eq", 2, 32'd0, 1'b0, 1'b0);
    issue(3'd1, 32'hF0F0_0000, 32'h0000_0F0F);
    finish_op("or", 2, 32'hF0F0_0F0F, 1'b0, 1'b0);

    issue(3'd5, 32'h0000_FFFF, 32'h0001_0001);
    chk("mul_alu_op", {30'd0, alu_op}, 32'd2);
    finish_op("mul_a", 33, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(3'd5, 32'h1234_5678, 32'd0);
    finish_op("mul_zero", 33, 32'd0, 1'b0, 1'b0);
    issue(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("mul_ones", 33, 32'd1, 1'b0, 1'b0);

    // Illegal opcode held under backpressure; new commands must be refused.
    rsp_ready = 1'b0;
    issue(3'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    wait_rsp("ill_lat", 1);
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_a     = 32'hF0F0_F0F0;
    cmd_b     = 32'hFF00_FF00;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_err", {31'd0, rsp_err}, 32'd1);
      chk("bp_data", rsp_data, 32'd0);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    cmd_valid = 1'b0;
    chk("bp_next_accepted", {31'd0, cmd_ready}, 32'd0);
    finish_op("bp_and", 2, 32'hF000_F000, 1'b0, 1'b0);

    // Reset partway through a multiply abandons it silently.
    issue(3'd5, 32'h0000_0003, 32'h0000_0005);
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("midrst_alu_ab", alu_a | alu_b, 32'd0);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) seen = 1'b1;
      step();
    end
    chk("midrst_no_rsp", {31'd0, seen}, 32'd0);
    issue(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    finish_op("and", 2, 32'hF000_F000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

- Command sequencer in front of the 32-bit ALU datapath (AND/OR/adder with b-invert and carry-in).
- Accepts one operation at a time over a valid/ready command port and drives the ALU control lines (`op`, `binvert`, `cin`) and operands.
- Captures the ALU result and returns it on a valid/ready response port.
- Derives SUB and SLT from the adder, and runs a multi-cycle 32×32 multiply (low 32 bits) by iterating the ALU adder.

## Interface
- No parameters; datapath width is fixed at 32.
- `clk  in  1` — single clock; all state updates on rising edge.
- `rst_n  in  1` — synchronous, active-low reset.
- `cmd_valid  in  1` — command present.
- `cmd_ready  out  1` — sequencer can accept a command.
- `cmd_op  in  3` — operation code:
  - 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 MUL.
  - 110 and 111 are illegal.
- `cmd_a  in  32` — operand A.
- `cmd_b  in  32` — operand B.
- `alu_a  out  32` — ALU operand a.
- `alu_b  out  32` — ALU operand b.
- `alu_op  out  2` — ALU result select: 00 AND, 01 OR, 10 adder.
- `alu_binvert  out  1` — ALU b-invert select.
- `alu_cin  out  1` — ALU adder carry-in.
- `alu_result  in  32` — combinational ALU result.
- `alu_cout  in  1` — adder carry out of bit 31.
- `rsp_valid  out  1` — response present.
- `rsp_ready  in  1` — consumer accepts response.
- `rsp_data  out  32` — operation result.
- `rsp_carry  out  1` — `alu_cout` for ADD/SUB; 0 for all other ops.
- `rsp_err  out  1` — illegal opcode.

## Operation
- **Reset** (rst_n=0 at a rising edge):
  - State returns to IDLE.
  - `rsp_valid`, `rsp_data`, `rsp_carry`, `rsp_err`, `alu_*` all become 0.
  - Iteration counter and accumulator are cleared.
  - `cmd_ready` = (state==IDLE) && rst_n, so it is 0 while reset is asserted.
  - Reset mid-operation abandons the operation with no response.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch op, A and B.
  - Legal non-MUL opcodes go to EXEC; MUL goes to MUL; 110/111 go to RESP with `rsp_data`=0 and `rsp_err`=1.
- **EXEC** (one cycle):
  - Drive `alu_a`=A and `alu_b`=B, with controls per op:
    - AND: 00/0/0.
    - OR: 01/0/0.
    - ADD: 10/0/0.
    - SUB and SLT: 10/1/1.
  - At the end of the cycle, capture `rsp_data`:
    - `alu_result` for all ops except SLT.
    - SLT: {31'b0, alu_result[31] ^ ovf}, where ovf = (A[31]≠B[31]) && (alu_result[31]≠A[31]).
  - `rsp_carry` = `alu_cout` for ADD/SUB, else 0.
  - Go to RESP.
- **MUL** (exactly 32 cycles, no early exit):
  - Registers: acc (init 0), mcand (init A), mplier (init B), 5-bit count (init 0).
  - Each cycle: `alu_a`=acc, `alu_b`=mcand, controls 10/0/0.
  - If mplier[0]=1, acc ← `alu_result`; otherwise acc holds.
  - mcand ← mcand<<1; mplier ← mplier>>1; count++.
  - When count==31, go to RESP with `rsp_data`=acc' (the acc value written on that final cycle), `rsp_carry`=0.
  - Result is the low 32 bits only; overflow is discarded silently.
- **RESP:**
  - `rsp_valid`=1; `rsp_data`, `rsp_carry` and `rsp_err` are held stable until the handshake.
  - On `rsp_ready`=1, go to IDLE and drop `rsp_valid` at the next edge.
- **ALU drive outside EXEC/MUL:** `alu_op`=00, `alu_binvert`=0, `alu_cin`=0, `alu_a`=`alu_b`=0.
- **Output timing:** ALU control and operand outputs are decoded from registered state, so they are glitch-free relative to `clk`.

## Timing
- **Latency**, counting from the accepting edge as edge 0:
  - AND/OR/ADD/SUB/SLT: `rsp_valid` high after edge 2.
  - Illegal opcode: `rsp_valid` high after edge 1.
  - MUL: `rsp_valid` high after edge 33.
- **Throughput:** no overlap between commands.
  - `cmd_ready` is low from edge 0 until the cycle after the response handshake.
  - Best case is one command per 3 cycles (single-cycle ops with `rsp_ready` tied high).
- **Backpressure:**
  - `rsp_ready` low holds RESP indefinitely with outputs frozen.
  - `cmd_valid` during non-IDLE states is ignored, and the command is not consumed.
- **Simultaneous events:**
  - A RESP handshake and a new `cmd_valid` in the same cycle: the command is not accepted, because `cmd_ready`=0 in RESP.
  - Reset has priority over every other event.

## Test plan
- **Reset behaviour:** hold `rst_n`=0 for 3 cycles with `cmd_valid`=1 → `cmd_ready`=0, `rsp_valid`=0, all `alu_*`=0. After release, `cmd_ready`=1 in the next cycle.
- **ADD and SUB:**
  - ADD A=0xFFFFFFFF, B=0x00000001 → `rsp_data`=0x00000000, `rsp_carry`=1, `rsp_valid` after edge 2.
  - SUB A=5, B=7 → `rsp_data`=0xFFFFFFFE, `rsp_carry`=0.
  - During EXEC for SUB, the bench checks `alu_op`=10, `alu_binvert`=1, `alu_cin`=1.
- **SLT with overflow:**
  - A=0x80000000, B=0x00000001 → 1.
  - A=0x7FFFFFFF, B=0xFFFFFFFF → 0.
  - A=3, B=3 → 0.
- **MUL:**
  - 0x0000FFFF × 0x00010001 → 0xFFFFFFFF, `rsp_valid` exactly after edge 33.
  - 0x12345678 × 0 → 0.
  - 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
- **Backpressure and illegal opcode:**
  - Op 110 with `rsp_ready`=0 for 10 cycles → `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0, stable throughout; `cmd_ready` stays 0 despite `cmd_valid`.
  - The next command is accepted one cycle after `rsp_ready`=1.
- **Reset mid-MUL:** assert `rst_n`=0 at iteration 10 → no response ever appears. A following AND of 0xF0F0F0F0 with 0xFF00FF00 → 0xF000F000.
